// File: rtl/piso_tx_pkg.sv
// Shared types and line levels for the piso_tx frame transmitter.
package piso_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_e;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;
endpackage

// File: rtl/piso_tx_if.sv
// Word handshake and serial-line bundle between a word source and piso_tx.
interface piso_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] p_in;
  logic             in_valid;
  logic             in_ready;
  logic             s_out;
  logic             busy;
  logic             done;

  modport master (output p_in, in_valid, input in_ready, s_out, busy, done);
  modport slave  (input p_in, in_valid, output in_ready, s_out, busy, done);
endinterface

// File: rtl/piso_tx_hold.sv
// Single-entry holding register: load on accept, pop when the shifter takes the word.
module piso_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);
  logic             full_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset)       full_q <= 1'b0;
    else if (load_i) full_q <= 1'b1;
    else if (pop_i)  full_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_i;
  end

  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/piso_tx.sv
// Framed PISO transmitter: start bit, data MSB-first, optional even parity, idle gap.
// Parity stage is built only when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic       clk,
  input logic       reset,
  piso_tx_if.slave  bus
);
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             s_out_q, s_out_d;
  logic             done_q, done_d;
  logic             hold_full, pop, accept, frame_end;
  logic [WIDTH-1:0] hold_data;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bus.in_ready = ~hold_full & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  piso_tx_hold #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .pop_i  (pop),
    .data_i (bus.p_in),
    .full_o (hold_full),
    .data_o (hold_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    sh_d      = sh_q;
    pop       = 1'b0;
    frame_end = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE:  pop = hold_full;
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = LAST_IDX;
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          frame_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: frame_end = 1'b1;
`endif
      ST_GAP: begin
        if (gap_q == '0) begin
          if (hold_full) pop = 1'b1;
          else           state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_LAST;
      end else if (hold_full) begin
        pop = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Shifter takes the held word on the same edge the hold register frees.
    if (pop) begin
      state_d = ST_START;
      sh_d    = hold_data;
`ifdef PISO_TX_PARITY_EN
      par_d   = ^hold_data;
`endif
    end

    // Line and done are registered, so they are decoded from the next state.
    case (state_d)
      ST_START:  s_out_d = START_LEVEL;
      ST_DATA:   s_out_d = sh_d[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: s_out_d = par_q;
`endif
      default:   s_out_d = IDLE_LEVEL;
    endcase
`ifdef PISO_TX_PARITY_EN
    done_d = (state_d == ST_PARITY);
`else
    done_d = (state_d == ST_DATA) && (cnt_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      s_out_q <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      s_out_q <= s_out_d;
      done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.s_out = s_out_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: GAP=1 and GAP=0 instances share stimulus; a frame-queue model predicts every cycle.
module tb_piso_tx;
  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int F = W + 1 + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] p_in = '0;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus0 ();
  piso_tx_if #(.WIDTH(W)) bus1 ();
  assign bus0.p_in = p_in;
  assign bus0.in_valid = in_valid;
  assign bus1.p_in = p_in;
  assign bus1.in_valid = in_valid;

  piso_tx #(.WIDTH(W), .GAP(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  piso_tx #(.WIDTH(W), .GAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  // Model: each instance owns a queue of {line bit, done} entries still to appear on the line.
  logic         m_full [2];
  logic [W-1:0] m_hold [2];
  logic [1:0]   mq [2][$];
  logic         m_sout [2];
  logic         m_done [2];
  logic         m_busy [2];
  logic         acc [2];

  logic [15:0]  hist_s = '0;
  logic [15:0]  hist_d = '0;
  int           ones0 = 0;
  int           ones1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int i, input logic [W-1:0] w, input int gap);
    mq[i].push_back(2'b10);
    for (int b = W - 1; b >= 0; b--) mq[i].push_back({w[b], (b == 0) && !PAR});
    if (PAR) mq[i].push_back({^w, 1'b1});
    for (int g = 0; g < gap; g++) mq[i].push_back(2'b00);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic       a;
      logic [1:0] e;
      acc[i] = 1'b0;
      if (reset) begin
        mq[i].delete();
        m_full[i] = 1'b0;
        m_sout[i] = 1'b0;
        m_done[i] = 1'b0;
        m_busy[i] = 1'b0;
      end else begin
        a = in_valid && !m_full[i];
        if (mq[i].size() == 0 && m_full[i]) begin
          push_frame(i, m_hold[i], (i == 0) ? 1 : 0);
          m_full[i] = 1'b0;
        end
        if (a) begin
          m_full[i] = 1'b1;
          m_hold[i] = p_in;
          acc[i]    = 1'b1;
        end
        if (mq[i].size() != 0) begin
          e = mq[i].pop_front();
          m_sout[i] = e[1];
          m_done[i] = e[0];
          m_busy[i] = 1'b1;
        end else begin
          m_sout[i] = 1'b0;
          m_done[i] = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("s_out0", bus0.s_out, m_sout[0]);
    chk("done0", bus0.done, m_done[0]);
    chk("busy0", bus0.busy, m_busy[0]);
    chk("ready0", bus0.in_ready, !m_full[0] && !reset);
    chk("s_out1", bus1.s_out, m_sout[1]);
    chk("done1", bus1.done, m_done[1]);
    chk("busy1", bus1.busy, m_busy[1]);
    chk("ready1", bus1.in_ready, !m_full[1] && !reset);
    hist_s = {hist_s[14:0], bus0.s_out};
    hist_d = {hist_d[14:0], bus0.done};
    ones0 += int'(bus0.s_out);
    ones1 += int'(bus1.s_out);
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    in_valid = v;
    p_in     = d;
    reset    = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    logic [15:0] exp_frame;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_hold[i] = '0; m_sout[i] = 1'b0;
      m_done[i] = 1'b0; m_busy[i] = 1'b0; acc[i] = 1'b0;
    end

    repeat (2) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("ready_after_rst", bus0.in_ready, 1);

    // Single 0xB3 frame, line sequence compared against the literal frame.
    cyc(1'b1, 8'hB3, 1'b0);
    repeat (F) cyc(1'b0, '0, 1'b0);
    exp_frame = PAR ? 16'h0367 : 16'h01B3;
    chk("b3_frame", 32'(hist_s & ((16'd1 << F) - 16'd1)), 32'(exp_frame));
    chk("b3_done", 32'(hist_d & ((16'd1 << F) - 16'd1)), 1);
    repeat (4) cyc(1'b0, '0, 1'b0);

    // Back-to-back: 0xA5 then 0x3C held valid until taken.
    cyc(1'b1, 8'hA5, 1'b0);
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, 8'h3C, 1'b0);
      if (acc[0]) break;
    end
    repeat (2 * F + 6) cyc(1'b0, '0, 1'b0);

    // Reset after the 4th data bit with a second word queued.
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    ones0 = 0;
    ones1 = 0;
    repeat (25) cyc(1'b0, '0, 1'b0);
    chk("no_send_after_rst0", ones0, 0);
    chk("no_send_after_rst1", ones1, 0);
    cyc(1'b1, 8'h96, 1'b0);
    repeat (F + 3) cyc(1'b0, '0, 1'b0);

    // Word offered while the hold register is full must be ignored.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    repeat (3 * F + 6) cyc(1'b0, '0, 1'b0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 800; n++) begin
      cyc($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 79) == 0);
    end
    repeat (3 * F) cyc(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
